alu_result_stage: RTL

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

---
 rtl/alu4_pkg.sv | 19 +
 rtl/alu_slot.sv | 23 ++
 rtl/alu_result_stage.sv | 123 ++++++++++++
 3 files changed

// File: rtl/alu4_pkg.sv
// Shared types for the ALU result stage: handshake state encoding and the
// record stored in each buffer slot.
package alu4_pkg;

   localparam int ALU_WIDTH = 4;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   typedef struct packed {
      logic [ALU_WIDTH-1:0] result;
      logic                 carry;
      logic                 zero;
   } slot_t;

endpackage

// File: rtl/alu_slot.sv
// One buffer slot: a load-enabled register holding a result record,
// cleared by synchronous reset.
module alu_slot
   import alu4_pkg::*;
#(
   parameter type T = slot_t
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  T     d,
   output T     q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/alu_result_stage.sv
// Two-entry skid buffer between the ALU and its consumer; in_ready is
// registered so the upstream never sees a combinational path from out_ready.
module alu_result_stage
   import alu4_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_result,
   input  logic             in_carry,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_carry,
   output logic             out_zero,
   output logic [CNT_W-1:0] xfer_cnt
);

   typedef struct packed {
      logic [WIDTH-1:0] result;
      logic             carry;
      logic             zero;
   } rec_t;

   state_t           state_q;
   state_t           state_nxt;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [CNT_W-1:0] cnt_q;
   logic             in_xfer;
   logic             out_xfer;
   logic             main_load;
   logic             skid_load;
   rec_t             in_rec;
   rec_t             main_d;
   rec_t             main_q;
   rec_t             skid_q;

   assign in_xfer  = in_valid && in_ready_q;
   assign out_xfer = out_valid_q && out_ready;

   // Zero flag is captured with the data so the output side needs no compare.
   assign in_rec.result = in_result;
   assign in_rec.carry  = in_carry;
   assign in_rec.zero   = (in_result == '0);

   always_comb begin
      state_nxt = state_q;
      main_load = 1'b0;
      skid_load = 1'b0;
      main_d    = in_rec;
      case (state_q)
         EMPTY: begin
            if (in_xfer) begin
               state_nxt = ONE;
               main_load = 1'b1;
            end
         end
         ONE: begin
            if (in_xfer && out_xfer) begin
               main_load = 1'b1;
            end else if (in_xfer) begin
               state_nxt = FULL;
               skid_load = 1'b1;
            end else if (out_xfer) begin
               state_nxt = EMPTY;
            end
         end
         FULL: begin
            if (out_xfer) begin
               state_nxt = ONE;
               main_load = 1'b1;
               main_d    = skid_q;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_nxt;
         in_ready_q  <= (state_nxt != FULL);
         out_valid_q <= (state_nxt != EMPTY);
         if (out_xfer) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   alu_slot #(.T(rec_t)) u_main (
      .clk  (clk),
      .rst  (rst),
      .load (main_load),
      .d    (main_d),
      .q    (main_q)
   );

   alu_slot #(.T(rec_t)) u_skid (
      .clk  (clk),
      .rst  (rst),
      .load (skid_load),
      .d    (in_rec),
      .q    (skid_q)
   );

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign out_result = main_q.result;
   assign out_carry  = main_q.carry;
   assign out_zero   = main_q.zero;
   assign xfer_cnt   = cnt_q;

endmodule
